serial_adder_ctrl: RTL and testbench

//  Bit-serial adder controller. Accepts two WIDTH-bit operands and a carry-in

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/full_adder.sv | 13 +
 rtl/serial_adder_ctrl.sv | 96 +++++++++
 tb/tb_serial_adder_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sadd_state_t;

   localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder shared by the serial add datapath.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: accepts operands over valid/ready, adds LSB-first through a
// single full_adder with a registered carry, and returns {cout, result} over valid/ready.
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   if (WIDTH < 2) begin : g_bad_width
      $error("serial_adder_ctrl: WIDTH must be >= 2");
   end

   sadd_state_t      state_q, state_d;
   logic [WIDTH-1:0] a_sr, b_sr, res_sr;
   logic             carry_q;
   logic [CW-1:0]    count_q;
   logic             fa_sum, fa_cout;
   logic             accept, release_res, last_bit;

   assign accept      = (state_q == IDLE) && in_valid;
   assign release_res = (state_q == DONE) && out_ready;
   assign last_bit    = (count_q == LAST);

   full_adder u_full_adder (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // NOTE: next state gets its default first so no path leaves it unassigned
   // (which would infer a latch).
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)      state_d = RUN;
         RUN:     if (last_bit)    state_d = DONE;
         DONE:    if (release_res) state_d = IDLE;
         default:                  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr    <= '0;
         b_sr    <= '0;
         res_sr  <= '0;
         carry_q <= 1'b0;
         count_q <= '0;
      end else if (accept) begin
         a_sr    <= op_a;
         b_sr    <= op_b;
         carry_q <= cin;
         count_q <= '0;
      end else if (state_q == RUN) begin
         a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
         b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
         res_sr  <= {fa_sum, res_sr[WIDTH-1:1]};
         carry_q <= fa_cout;
         // Hold on the last bit so the counter never wraps for power-of-two widths.
         count_q <= last_bit ? count_q : count_q + CW'(1);
      end
   end

   // Result is gated to DONE so a stale or partial sum is never visible.
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign result    = out_valid ? res_sr : '0;
   assign cout      = out_valid & carry_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=8 and WIDTH=16 against an
// arithmetic reference model.
module tb_serial_adder_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        iv8, ir8, ov8, or8, ci8, co8, busy8;
   logic [7:0]  a8, b8, r8;
   logic        iv16, ir16, ov16, or16, ci16, co16, busy16;
   logic [15:0] a16, b16, r16;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [15:0] res;
      logic        co;
   } exp_t;

   serial_adder_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .op_a(a8), .op_b(b8),
      .cin(ci8), .out_valid(ov8), .out_ready(or8), .result(r8), .cout(co8), .busy(busy8)
   );

   serial_adder_ctrl #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .op_a(a16), .op_b(b16),
      .cin(ci16), .out_valid(ov16), .out_ready(or16), .result(r16), .cout(co16), .busy(busy16)
   );

   task automatic drive(input int w, input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic c);
      if (w == 8) begin iv8 = v; a8 = a[7:0]; b8 = b[7:0]; ci8 = c; end
      else begin iv16 = v; a16 = a; b16 = b; ci16 = c; end
   endtask

   task automatic set_ready(input int w, input logic r);
      if (w == 8) or8 = r; else or16 = r;
   endtask

   function automatic logic rd_ir(input int w);   return (w == 8) ? ir8 : ir16;     endfunction
   function automatic logic rd_ov(input int w);   return (w == 8) ? ov8 : ov16;     endfunction
   function automatic logic rd_busy(input int w); return (w == 8) ? busy8 : busy16; endfunction
   function automatic logic rd_co(input int w);   return (w == 8) ? co8 : co16;     endfunction
   function automatic logic [15:0] rd_res(input int w);
      return (w == 8) ? {8'h00, r8} : r16;
   endfunction

   // Reference: plain integer sum, split into low w bits and the carry out of bit w-1.
   task automatic model(input int w, input logic [15:0] a, input logic [15:0] b, input logic c,
                        output logic [15:0] er, output logic ec);
      int s;
      s  = int'(a) + int'(b) + int'(c);
      er = 16'(s % (1 << w));
      ec = ((s >> w) & 1) != 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full transaction: accept, latency, optional backpressure, release.
   task automatic do_op(input int w, input logic [15:0] a, input logic [15:0] b, input logic c,
                        input int hold, input bit pulse, input string name);
      logic [15:0] er;
      logic        ec;
      int          n;
      model(w, a, b, c, er, ec);
      n = 0;
      while (rd_ir(w) !== 1'b1 && n < 100) begin step(); n++; end
      checks++;
      if (rd_ir(w) !== 1'b1) begin errors++; $display("FAIL %s ready_wait in_ready=%b want 1", name, rd_ir(w)); end
      drive(w, 1'b1, a, b, c);
      step();
      drive(w, 1'b0, '0, '0, 1'b0);
      checks++;
      if (rd_busy(w) !== 1'b1 || rd_ir(w) !== 1'b0 || rd_ov(w) !== 1'b0) begin
         errors++;
         $display("FAIL %s after_accept busy=%b in_ready=%b out_valid=%b want 1/0/0",
                  name, rd_busy(w), rd_ir(w), rd_ov(w));
      end
      n = 0;
      for (int k = 1; k <= w; k++) begin
         step();
         if (rd_ov(w) === 1'b1 && n == 0) n = k;
      end
      checks++;
      if (n != w) begin errors++; $display("FAIL %s latency got %0d edges want %0d", name, n, w); end
      checks++;
      if (rd_res(w) !== er || rd_co(w) !== ec) begin
         errors++;
         $display("FAIL %s result got %h/%b want %h/%b", name, rd_res(w), rd_co(w), er, ec);
      end
      for (int h = 0; h < hold; h++) begin
         if (pulse && h == 2) drive(w, 1'b1, 16'h0011, 16'h0000, 1'b0);
         step();
         drive(w, 1'b0, '0, '0, 1'b0);
         checks++;
         if (rd_ov(w) !== 1'b1 || rd_ir(w) !== 1'b0 || rd_res(w) !== er || rd_co(w) !== ec) begin
            errors++;
            $display("FAIL %s hold%0d out_valid=%b in_ready=%b result=%h cout=%b want 1/0/%h/%b",
                     name, h, rd_ov(w), rd_ir(w), rd_res(w), rd_co(w), er, ec);
         end
      end
      set_ready(w, 1'b1);
      step();
      set_ready(w, 1'b0);
      checks++;
      if (rd_ov(w) !== 1'b0 || rd_ir(w) !== 1'b1 || rd_busy(w) !== 1'b0) begin
         errors++;
         $display("FAIL %s release out_valid=%b in_ready=%b busy=%b want 0/1/0",
                  name, rd_ov(w), rd_ir(w), rd_busy(w));
      end
   endtask

   task automatic test_reset();
      drive(8, 1'b0, '0, '0, 1'b0);  set_ready(8, 1'b0);
      drive(16, 1'b0, '0, '0, 1'b0); set_ready(16, 1'b0);
      rst_n = 1'b0;
      repeat (2) step();
      checks++;
      if (ir8 !== 1'b1 || ov8 !== 1'b0 || busy8 !== 1'b0 || r8 !== 8'h00 || co8 !== 1'b0) begin
         errors++;
         $display("FAIL reset8 in_ready=%b out_valid=%b busy=%b result=%h cout=%b want 1/0/0/00/0",
                  ir8, ov8, busy8, r8, co8);
      end
      checks++;
      if (ir16 !== 1'b1 || ov16 !== 1'b0 || busy16 !== 1'b0 || r16 !== 16'h0 || co16 !== 1'b0) begin
         errors++;
         $display("FAIL reset16 in_ready=%b out_valid=%b busy=%b result=%h cout=%b want 1/0/0/0000/0",
                  ir16, ov16, busy16, r16, co16);
      end
      rst_n = 1'b1;
      step();
      checks++;
      if (ir8 !== 1'b1 || busy8 !== 1'b0 || ov8 !== 1'b0) begin
         errors++;
         $display("FAIL post_reset8 in_ready=%b busy=%b out_valid=%b want 1/0/0", ir8, busy8, ov8);
      end
   endtask

   task automatic test_directed();
      do_op(8, 16'h00FF, 16'h0001, 1'b0, 0, 1'b0, "ff_plus_01");
      do_op(8, 16'h005A, 16'h00A5, 1'b1, 0, 1'b0, "5a_a5_c1");
      do_op(8, 16'h003C, 16'h0042, 1'b0, 0, 1'b0, "3c_plus_42");
      do_op(16, 16'hFFFF, 16'h0000, 1'b1, 1, 1'b0, "w16_wrap");
   endtask

   task automatic test_backpressure();
      do_op(8, 16'h0077, 16'h0099, 1'b0, 5, 1'b1, "backpressure");
      checks++;
      if (busy8 !== 1'b0 || ir8 !== 1'b1) begin
         errors++;
         $display("FAIL bp_no_capture busy=%b in_ready=%b want 0/1", busy8, ir8);
      end
      do_op(8, 16'h0023, 16'h0045, 1'b1, 0, 1'b0, "after_backpressure");
   endtask

   task automatic test_reset_mid_run();
      drive(8, 1'b1, 16'h00AB, 16'h00CD, 1'b1);
      step();
      drive(8, 1'b0, '0, '0, 1'b0);
      repeat (3) step();
      rst_n = 1'b0;
      #1;
      checks++;
      if (ov8 !== 1'b0 || busy8 !== 1'b0 || ir8 !== 1'b1 || r8 !== 8'h00) begin
         errors++;
         $display("FAIL mid_reset out_valid=%b busy=%b in_ready=%b result=%h want 0/0/1/00",
                  ov8, busy8, ir8, r8);
      end
      step();
      rst_n = 1'b1;
      step();
      checks++;
      if (ov8 !== 1'b0 || busy8 !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_release out_valid=%b busy=%b want 0/0", ov8, busy8);
      end
      do_op(8, 16'h0010, 16'h0020, 1'b0, 0, 1'b0, "after_mid_reset");
   endtask

   // in_valid held through DONE is accepted on the first IDLE cycle.
   task automatic test_back_to_back();
      logic [15:0] er;
      logic        ec;
      int          n;
      drive(8, 1'b1, 16'h0080, 16'h0080, 1'b0);
      step();
      drive(8, 1'b1, 16'h00C3, 16'h0011, 1'b1);
      n = 1;
      while (ov8 !== 1'b1 && n < 50) begin step(); n++; end
      checks++;
      if (n != 9) begin errors++; $display("FAIL b2b_first_latency got %0d want 9", n); end
      set_ready(8, 1'b1);
      step();
      set_ready(8, 1'b0);
      checks++;
      if (ir8 !== 1'b1 || ov8 !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle in_ready=%b out_valid=%b want 1/0", ir8, ov8);
      end
      step();
      drive(8, 1'b0, '0, '0, 1'b0);
      checks++;
      if (busy8 !== 1'b1 || ir8 !== 1'b0) begin
         errors++;
         $display("FAIL b2b_second_accept busy=%b in_ready=%b want 1/0", busy8, ir8);
      end
      repeat (8) step();
      model(8, 16'h00C3, 16'h0011, 1'b1, er, ec);
      checks++;
      if (ov8 !== 1'b1 || {8'h00, r8} !== er || co8 !== ec) begin
         errors++;
         $display("FAIL b2b_second_result out_valid=%b result=%h cout=%b want 1/%h/%b",
                  ov8, r8, co8, er[7:0], ec);
      end
      set_ready(8, 1'b1);
      step();
      set_ready(8, 1'b0);
   endtask

   task automatic test_random(input int w, input int nops);
      logic [15:0] ca, cb, mask, er;
      logic        cc, ec, pend, rdy;
      int          acc, got, cyc;
      exp_t        q[$];
      exp_t        e;
      mask = (w == 8) ? 16'h00FF : 16'hFFFF;
      pend = 1'b0; acc = 0; got = 0; cyc = 0;
      ca = '0; cb = '0; cc = 1'b0;
      while ((acc < nops || got < acc) && cyc < 40000) begin
         if (!pend && acc < nops && $urandom_range(0, 2) != 0) begin
            ca = 16'($urandom) & mask;
            cb = 16'($urandom) & mask;
            cc = 1'($urandom);
            pend = 1'b1;
         end
         drive(w, pend, ca, cb, cc);
         rdy = ($urandom_range(0, 3) != 0);
         set_ready(w, rdy);
         if (pend && rd_ir(w) === 1'b1) begin
            model(w, ca, cb, cc, er, ec);
            q.push_back('{res: er, co: ec});
            acc++;
            pend = 1'b0;
         end
         if (rd_ov(w) === 1'b1 && rdy) begin
            got++;
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL rand%0d extra_result result=%h with nothing outstanding", w, rd_res(w));
            end else begin
               e = q.pop_front();
               if (rd_res(w) !== e.res || rd_co(w) !== e.co) begin
                  errors++;
                  $display("FAIL rand%0d op%0d got %h/%b want %h/%b", w, got, rd_res(w), rd_co(w),
                           e.res, e.co);
               end
            end
         end
         step();
         cyc++;
      end
      drive(w, 1'b0, '0, '0, 1'b0);
      set_ready(w, 1'b0);
      checks++;
      if (acc != nops || got != nops || q.size() != 0) begin
         errors++;
         $display("FAIL rand%0d accounting accepted=%0d returned=%0d pending=%0d want %0d/%0d/0",
                  w, acc, got, q.size(), nops, nops);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid_run();
      test_back_to_back();
      test_random(8, 500);
      test_random(16, 500);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
